led_pio_pwm: RTL
================

LED_PIO_PWM -- requirements
Module: led_pio_pwm

Interface
REQ-001 Parameter WIDTH, default 18: number of output channels, legal 1..32.
REQ-002 Parameter PRESCALE_W, default 16: width of the blink prescaler counter and PERIOD register, legal 1..32.
REQ-003 Parameter RESET_VALUE, default 0: WIDTH-bit DATA value after reset.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 address  in  3  register word select.
REQ-007 chipselect  in  1  slave select.
REQ-008 write_n  in  1  active-low write strobe; write = chipselect && !write_n.
REQ-009 writedata  in  32  write data.
REQ-010 readdata  out  32  read data, combinational from address, zero-extended.
REQ-011 out_port  out  WIDTH  registered channel outputs.

Function
REQ-012 Register map SHALL be: 0 DATA rw; 1 MODE rw (bit i=1: channel i blinks); 2 SET wo; 3 CLEAR wo; 4 TOGGLE wo; 5 PERIOD rw (PRESCALE_W bits); 6 DUTY rw (8 bits); 7 STATUS ro (bit0 = blink phase).
REQ-013 Writes SHALL take effect on the clock edge of the write cycle, using writedata[WIDTH-1:0] (or [PRESCALE_W-1:0] / [7:0]); unused upper bits are ignored.
REQ-014 SET write SHALL perform DATA |= wd; CLEAR: DATA &= ~wd; TOGGLE: DATA ^= wd; DATA is modified only by writes.
REQ-015 Reads of SET, CLEAR, TOGGLE SHALL return 0; all reads have zero wait states and no side effects.
REQ-016 Prescaler: down-counter cnt; when cnt==0, a one-cycle tick fires, cnt reloads PERIOD and phase inverts; otherwise cnt decrements.
REQ-017 PERIOD=N SHALL give a tick every N+1 cycles; PERIOD=0 gives a tick every cycle.
REQ-018 A write to PERIOD SHALL load cnt with the new value on the same edge and suppress any tick that cycle; phase is unchanged.
REQ-019 PWM: 8-bit free-running counter pwm_cnt, wraps 255->0; pwm_on = (DUTY==255) || (pwm_cnt < DUTY); DUTY=0 means always off.
REQ-020 Next out_port[i] SHALL be DATA[i] & pwm_on & (!MODE[i] | phase), computed from the register values before the current edge, giving one cycle of latency from a write to the pin.
REQ-021 When a DATA-modifying write and a tick occur in the same cycle, both SHALL take effect; neither is lost.
REQ-022 Write with address outside 0..6, or to STATUS, SHALL have no effect.

Reset
REQ-023 While reset=1, the block SHALL set DATA=RESET_VALUE, MODE=0, PERIOD=all ones, DUTY=255, cnt=all ones, phase=0, pwm_cnt=0, out_port=0.
REQ-024 On the first edge after reset deasserts, out_port SHALL take RESET_VALUE (MODE=0, DUTY=255).
REQ-025 Reset asserted mid-blink or mid-write SHALL clear state immediately, with no clock required; the pending write is discarded.

Verification
REQ-026 Write DATA=0x3FFFF, then SET 0x1, CLEAR 0x2, TOGGLE 0x4 -> DATA reads 0x3FFF9; out_port=0x3FFF9 one cycle after the last write.
REQ-027 Write PERIOD=3, MODE=0x1, DATA=0x1 -> out_port[0] alternates 4 cycles on / 4 cycles off; STATUS bit0 tracks phase.
REQ-028 Write DUTY=64, DATA=0x1 -> out_port[0] high for exactly 64 of every 256 cycles; DUTY=0 -> always 0; DUTY=255 -> always 1.
REQ-029 Issue a TOGGLE write on the same cycle as a tick with PERIOD=0 -> both the toggled DATA and the inverted phase appear on the next edge.
REQ-030 Assert reset asynchronously between edges during blinking -> out_port=0 and all registers at their reset values immediately; WIDTH=1 and WIDTH=32 builds pass REQ-026.

Source files
------------

// File: rtl/led_pio_pwm.sv
// LED parallel output port with per-channel blink and global PWM dimming.
// Eight-word register window: DATA, MODE, SET, CLEAR, TOGGLE, PERIOD, DUTY, STATUS.
module led_pio_pwm #(
    parameter int unsigned      WIDTH       = 18,
    parameter int unsigned      PRESCALE_W  = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] AddrData   = 3'd0;
    localparam logic [2:0] AddrMode   = 3'd1;
    localparam logic [2:0] AddrSet    = 3'd2;
    localparam logic [2:0] AddrClear  = 3'd3;
    localparam logic [2:0] AddrToggle = 3'd4;
    localparam logic [2:0] AddrPeriod = 3'd5;
    localparam logic [2:0] AddrDuty   = 3'd6;
    localparam logic [2:0] AddrStatus = 3'd7;

    logic [WIDTH-1:0]      data_q, data_d;
    logic [WIDTH-1:0]      mode_q, mode_d;
    logic [PRESCALE_W-1:0] period_q, period_d;
    logic [7:0]            duty_q, duty_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic                  phase_q, phase_d;
    logic [7:0]            pwm_cnt_q, pwm_cnt_d;
    logic [WIDTH-1:0]      out_q, out_d;

    logic                  wr_en;
    logic                  period_wr;
    logic                  tick;
    logic                  pwm_on;
    logic [WIDTH-1:0]      wd_data;

    // Writedata bits above the addressed register width are deliberately ignored.
    logic unused_wd;
    assign unused_wd = ^writedata;

    assign wr_en   = chipselect && !write_n;
    assign wd_data = writedata[WIDTH-1:0];

    // Register-file next state from bus writes.
    always_comb begin
        data_d   = data_q;
        mode_d   = mode_q;
        period_d = period_q;
        duty_d   = duty_q;
        if (wr_en) begin
            case (address)
                AddrData:   data_d   = wd_data;
                AddrMode:   mode_d   = wd_data;
                AddrSet:    data_d   = data_q | wd_data;
                AddrClear:  data_d   = data_q & ~wd_data;
                AddrToggle: data_d   = data_q ^ wd_data;
                AddrPeriod: period_d = writedata[PRESCALE_W-1:0];
                AddrDuty:   duty_d   = writedata[7:0];
                default:    ;
            endcase
        end
    end

    // Blink prescaler and PWM counter; a PERIOD write restarts the count and eats that tick.
    always_comb begin
        period_wr = wr_en && (address == AddrPeriod);
        tick      = (cnt_q == '0) && !period_wr;
        if (period_wr) begin
            cnt_d = writedata[PRESCALE_W-1:0];
        end else if (cnt_q == '0) begin
            cnt_d = period_q;
        end else begin
            cnt_d = cnt_q - PRESCALE_W'(1);
        end
        phase_d   = phase_q ^ tick;
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        pwm_on    = (duty_q == 8'hFF) || (pwm_cnt_q < duty_q);
        out_d     = data_q & {WIDTH{pwm_on}} & (~mode_q | {WIDTH{phase_q}});
    end

    // Combinational, side-effect-free read mux; write-only words read as zero.
    always_comb begin
        readdata = '0;
        case (address)
            AddrData:   readdata[WIDTH-1:0]      = data_q;
            AddrMode:   readdata[WIDTH-1:0]      = mode_q;
            AddrPeriod: readdata[PRESCALE_W-1:0] = period_q;
            AddrDuty:   readdata[7:0]            = duty_q;
            AddrStatus: readdata[0]              = phase_q;
            default:    readdata = '0;
        endcase
    end

    // All state, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= RESET_VALUE;
            mode_q    <= '0;
            period_q  <= '1;
            duty_q    <= 8'hFF;
            cnt_q     <= '1;
            phase_q   <= 1'b0;
            pwm_cnt_q <= 8'd0;
            out_q     <= '0;
        end else begin
            data_q    <= data_d;
            mode_q    <= mode_d;
            period_q  <= period_d;
            duty_q    <= duty_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            pwm_cnt_q <= pwm_cnt_d;
            out_q     <= out_d;
        end
    end

    assign out_port = out_q;

endmodule
